// File: rtl/rf_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rf_cmd_ctrl_pkg
//   Shared types and constants for the register-file command controller.
//   - state_t      : controller FSM state encoding
//   - WR_CMD_DEF   : default opcode for a register write
//   - RD_CMD_DEF   : default opcode for a register read
//   - state_busy() : true for every state that is part of a command in flight
// -----------------------------------------------------------------------------
package rf_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

    localparam logic [7:0] WR_CMD_DEF = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF = 8'hBB;

    function automatic logic state_busy(input state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/rf_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// rf_cmd_ctrl_if
//   Bundles the command-receive, register-file and transmit signals of the
//   register-file command controller.
//   Modports:
//     master : the controller (consumes RX/TX-busy/read-data, drives RF + TX)
//     slave  : the surrounding system (UART RX/TX and register file side)
//   Signals:
//     RX_P_Data / RX_D_VLD      : received command byte + one-cycle strobe
//     TX_Busy                   : transmitter cannot accept a byte
//     Rd_Data / Rd_Data_VLD     : register-file read return
//     WrEN / RdEN               : register-file write / read enables
//     Address / WrData          : register-file address / write data
//     TX_P_Data / TX_D_VLD      : response byte + one-cycle strobe
//     Busy                      : controller is processing a command
// -----------------------------------------------------------------------------
interface rf_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 4
);
    logic [DATA_WIDTH-1:0] RX_P_Data;
    logic                  RX_D_VLD;
    logic                  TX_Busy;
    logic [DATA_WIDTH-1:0] Rd_Data;
    logic                  Rd_Data_VLD;
    logic                  WrEN;
    logic                  RdEN;
    logic [ADDR_SIZE-1:0]  Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] TX_P_Data;
    logic                  TX_D_VLD;
    logic                  Busy;

    modport master (
        input  RX_P_Data, RX_D_VLD, TX_Busy, Rd_Data, Rd_Data_VLD,
        output WrEN, RdEN, Address, WrData, TX_P_Data, TX_D_VLD, Busy
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, TX_Busy, Rd_Data, Rd_Data_VLD,
        input  WrEN, RdEN, Address, WrData, TX_P_Data, TX_D_VLD, Busy
    );
endinterface

// File: rtl/rf_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rf_cmd_ctrl
//   Decodes a byte stream of register-file commands:
//     write : WR_CMD, addr, data  -> one-cycle WrEN, no response
//     read  : RD_CMD, addr        -> one-cycle RdEN, wait for Rd_Data_VLD,
//                                    then send the read byte to the transmitter
//   Unknown opcodes in IDLE are dropped. Bytes arriving while a command is
//   executing, waiting for read data or waiting for the transmitter are dropped.
//   Every output is a flop; the next-state logic feeds the output registers so
//   pulses line up with the state they belong to.
//
//   Ports:
//     CLK     : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     bus     : rf_cmd_ctrl_if.master (RX, register file, TX signals)
//     Cmd_Err : (only with RF_CMD_ERR_EN) one-cycle pulse after an unknown
//               opcode is seen in IDLE
//
//   Optional feature macro: RF_CMD_ERR_EN
// -----------------------------------------------------------------------------
module rf_cmd_ctrl
    import rf_cmd_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_SIZE  = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = DATA_WIDTH'(WR_CMD_DEF),
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = DATA_WIDTH'(RD_CMD_DEF)
) (
    input  logic          CLK,
    input  logic          rst_n,
`ifdef RF_CMD_ERR_EN
    rf_cmd_ctrl_if.master bus,
    output logic          Cmd_Err
`else
    rf_cmd_ctrl_if.master bus
`endif
);

    state_t state;
    state_t state_nxt;

    logic addr_cap;
    logic data_cap;
    logic rdata_cap;
    logic tx_fire;
`ifdef RF_CMD_ERR_EN
    logic cmd_unknown;
`endif

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and capture enables
    always_comb begin
        state_nxt = state;
        addr_cap  = 1'b0;
        data_cap  = 1'b0;
        rdata_cap = 1'b0;
        tx_fire   = 1'b0;
`ifdef RF_CMD_ERR_EN
        cmd_unknown = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_Data == WR_CMD) begin
                        state_nxt = WR_ADDR;
                    end else if (bus.RX_P_Data == RD_CMD) begin
                        state_nxt = RD_ADDR;
                    end else begin
`ifdef RF_CMD_ERR_EN
                        cmd_unknown = 1'b1;
`endif
                    end
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_cap  = 1'b1;
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    data_cap  = 1'b1;
                    state_nxt = WR_EXEC;
                end
            end
            WR_EXEC: begin
                state_nxt = IDLE;
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_cap  = 1'b1;
                    state_nxt = RD_EXEC;
                end
            end
            RD_EXEC: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.Rd_Data_VLD) begin
                    rdata_cap = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!bus.TX_Busy) begin
                    tx_fire   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs. Enables are decoded from the next state so that
    // WrEN/RdEN are high exactly during WR_EXEC/RD_EXEC; being mutually
    // exclusive states, the two enables can never overlap.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bus.WrEN      <= 1'b0;
            bus.RdEN      <= 1'b0;
            bus.Busy      <= 1'b0;
            bus.TX_D_VLD  <= 1'b0;
            bus.Address   <= '0;
            bus.WrData    <= '0;
            bus.TX_P_Data <= '0;
        end else begin
            bus.WrEN     <= (state_nxt == WR_EXEC);
            bus.RdEN     <= (state_nxt == RD_EXEC);
            bus.Busy     <= state_busy(state_nxt);
            bus.TX_D_VLD <= tx_fire;
            if (addr_cap) begin
                // Only the low address bits are meaningful; the rest are dropped.
                bus.Address <= bus.RX_P_Data[ADDR_SIZE-1:0];
            end
            if (data_cap) begin
                bus.WrData <= bus.RX_P_Data;
            end
            if (rdata_cap) begin
                bus.TX_P_Data <= bus.Rd_Data;
            end
        end
    end

`ifdef RF_CMD_ERR_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Cmd_Err <= 1'b0;
        end else begin
            Cmd_Err <= cmd_unknown;
        end
    end
`endif

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
module tb_rf_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();

`ifdef RF_CMD_ERR_EN
    logic cmd_err;
    rf_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .WR_CMD(8'hAA), .RD_CMD(8'hBB)) dut (
        .CLK(clk), .rst_n(rst_n), .bus(bus), .Cmd_Err(cmd_err)
    );
`else
    rf_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .WR_CMD(8'hAA), .RD_CMD(8'hBB)) dut (
        .CLK(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    int total = 0;
    int bad   = 0;

    // Observed events, one entry per cycle the strobe is high
    int wr_q[$];
    int rd_q[$];
    int tx_q[$];
    int err_cnt     = 0;
    int overlap_cnt = 0;

    // Emulated register file (responds to the DUT) and the reference model
    logic [DW-1:0] rf_mem  [16] = '{default: 8'h11};
    logic [DW-1:0] ref_mem [16] = '{default: 8'h11};

    int            rd_lat  = 1;
    int            rd_cnt  = 0;
    logic [AW-1:0] rd_addr = '0;

    // Register-file responder and output monitor
    always @(negedge clk) begin
        bus.Rd_Data_VLD = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin
                bus.Rd_Data_VLD = 1'b1;
                bus.Rd_Data     = rf_mem[rd_addr];
            end
        end
        if (bus.RdEN) begin
            rd_cnt  = rd_lat;
            rd_addr = bus.Address;
            rd_q.push_back(int'(bus.Address));
        end
        if (bus.WrEN) begin
            wr_q.push_back(int'({bus.Address, bus.WrData}));
            rf_mem[bus.Address] = bus.WrData;
        end
        if (bus.TX_D_VLD) tx_q.push_back(int'(bus.TX_P_Data));
        if (bus.WrEN && bus.RdEN) overlap_cnt++;
`ifdef RF_CMD_ERR_EN
        if (cmd_err) err_cnt++;
`endif
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        @(negedge clk);
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, int'(n < 200), 1);
        repeat (2) @(negedge clk);
    endtask

    // Compare collected events against the expected transaction, then clear
    task automatic check_q(input string tag,
                           input int wr_n, input int wr_v,
                           input int rd_n, input int rd_v,
                           input int tx_n, input int tx_v);
        check({tag, "_wr_cnt"}, wr_q.size(), wr_n);
        if (wr_n == 1 && wr_q.size() == 1) check({tag, "_wr_val"}, wr_q[0], wr_v);
        check({tag, "_rd_cnt"}, rd_q.size(), rd_n);
        if (rd_n == 1 && rd_q.size() == 1) check({tag, "_rd_addr"}, rd_q[0], rd_v);
        check({tag, "_tx_cnt"}, tx_q.size(), tx_n);
        if (tx_n == 1 && tx_q.size() == 1) check({tag, "_tx_val"}, tx_q[0], tx_v);
        wr_q.delete();
        rd_q.delete();
        tx_q.delete();
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        wait_idle(tag);
        check_q(tag, 1, int'({a[AW-1:0], d}), 0, 0, 0, 0);
        ref_mem[a[AW-1:0]] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] op;
        int         kind;
        int         hold;

        bus.RX_P_Data = '0;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_Busy   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wren",  int'(bus.WrEN), 0);
        check("rst_rden",  int'(bus.RdEN), 0);
        check("rst_txvld", int'(bus.TX_D_VLD), 0);
        check("rst_busy",  int'(bus.Busy), 0);
        check("rst_addr",  int'(bus.Address), 0);
        check("rst_wdata", int'(bus.WrData), 0);
        check("rst_txdat", int'(bus.TX_P_Data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write
        do_write("wr_basic", 8'h05, 8'h3C);
        check("wr_addr_hold",  int'(bus.Address), 5);
        check("wr_wdata_hold", int'(bus.WrData), 8'h3C);

        // Basic read, data one cycle after RdEN
        rd_lat = 1;
        send_byte(8'hBB);
        send_byte(8'h02);
        wait_idle("rd_basic");
        check_q("rd_basic", 0, 0, 1, 2, 1, 8'h11);

        // Back-pressure: transmitter busy for a long stretch
        bus.TX_Busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h05);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_txvld", int'(bus.TX_D_VLD), 0);
            check("bp_txdat_stable", int'(bus.TX_P_Data), 8'h3C);
        end
        check("bp_busy_held", int'(bus.Busy), 1);
        bus.TX_Busy = 1'b0;
        wait_idle("bp");
        check_q("bp", 0, 0, 1, 5, 1, 8'h3C);

        // Unknown opcode
        err_cnt = 0;
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) begin
            check("unk_busy", int'(bus.Busy), 0);
            @(negedge clk);
        end
        check_q("unk", 0, 0, 0, 0, 0, 0);
`ifdef RF_CMD_ERR_EN
        check("unk_cmd_err", err_cnt, 1);
`endif

        // Reset in the middle of a write
        send_byte(8'hAA);
        send_byte(8'h07);
        check("midrst_addr_before", int'(bus.Address), 7);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", int'(bus.Address), 0);
        check("midrst_busy", int'(bus.Busy), 0);
        check("midrst_wdata", int'(bus.WrData), 0);
        check("midrst_wren", int'(bus.WrEN), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h3C);
        repeat (4) @(negedge clk);
        check("midrst_busy_after", int'(bus.Busy), 0);
        check_q("midrst", 0, 0, 0, 0, 0, 0);

        // Byte arriving while waiting for read data is dropped
        rd_lat = 5;
        send_byte(8'hBB);
        send_byte(8'h03);
        send_byte(8'hAA);
        wait_idle("drop");
        check_q("drop", 0, 0, 1, 3, 1, int'(ref_mem[3]));
        check("drop_busy", int'(bus.Busy), 0);
        do_write("drop_after", 8'h03, 8'h77);

        // Randomized command mix against the reference model
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            a    = 8'($urandom);
            d    = 8'($urandom);
            if (kind == 0) begin
                do_write("rnd_wr", a, d);
            end else if (kind == 1) begin
                rd_lat = int'($urandom_range(1, 4));
                hold   = int'($urandom_range(0, 6));
                bus.TX_Busy = (hold != 0);
                send_byte(8'hBB);
                send_byte(a);
                repeat (hold) @(negedge clk);
                bus.TX_Busy = 1'b0;
                wait_idle("rnd_rd");
                check_q("rnd_rd", 0, 0, 1, int'(a[AW-1:0]), 1, int'(ref_mem[a[AW-1:0]]));
            end else begin
                op = d;
                if (op == 8'hAA || op == 8'hBB) op = 8'h55;
                send_byte(op);
                repeat (3) @(negedge clk);
                check("rnd_unk_busy", int'(bus.Busy), 0);
                check_q("rnd_unk", 0, 0, 0, 0, 0, 0);
            end
        end

        check("wr_rd_exclusive", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_cmd_ctrl.md
RF_CMD_CTRL -- requirements
Module: rf_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of command bytes and register data.
REQ-002 Parameter ADDR_SIZE, default 4, register-file address width.
REQ-003 Parameter WR_CMD, default 8'hAA, opcode for a register write.
REQ-004 Parameter RD_CMD, default 8'hBB, opcode for a register read.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 RX_P_Data  input  DATA_WIDTH  received command byte.
REQ-008 RX_D_VLD  input  1  one-cycle strobe, RX_P_Data valid.
REQ-009 TX_Busy  input  1  transmitter busy; high means do not offer a byte.
REQ-010 Rd_Data  input  DATA_WIDTH  register-file read data.
REQ-011 Rd_Data_VLD  input  1  register-file read data valid.
REQ-012 WrEN  output  1  register-file write enable.
REQ-013 RdEN  output  1  register-file read enable.
REQ-014 Address  output  ADDR_SIZE  register-file address.
REQ-015 WrData  output  DATA_WIDTH  register-file write data.
REQ-016 TX_P_Data  output  DATA_WIDTH  response byte to transmitter.
REQ-017 TX_D_VLD  output  1  one-cycle strobe, TX_P_Data valid.
REQ-018 Busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
REQ-020 IDLE: RX_D_VLD with WR_CMD -> WR_ADDR; with RD_CMD -> RD_ADDR; any other byte -> stay IDLE.
REQ-021 WR_ADDR/RD_ADDR: on RX_D_VLD, latch RX_P_Data[ADDR_SIZE-1:0] into Address (upper bits discarded) and go to WR_DATA or RD_EXEC respectively.
REQ-022 WR_DATA: on RX_D_VLD, latch RX_P_Data into WrData and go to WR_EXEC.
REQ-023 WR_EXEC: WrEN SHALL be high for exactly this one cycle, then IDLE; no response byte is sent for writes.
REQ-024 RD_EXEC: RdEN SHALL be high for exactly this one cycle, then RD_WAIT.
REQ-025 RD_WAIT: on Rd_Data_VLD, latch Rd_Data into TX_P_Data and go to TX_SEND.
REQ-026 TX_SEND: when TX_Busy is low, TX_D_VLD SHALL be high for one cycle and the FSM returns to IDLE; while TX_Busy is high, hold state and TX_P_Data.
REQ-027 WrEN and RdEN SHALL never be high in the same cycle.
REQ-028 RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND SHALL be ignored (byte dropped).
REQ-029 Address and WrData SHALL hold their last latched values outside capture states.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE; WrEN, RdEN, TX_D_VLD, Busy = 0; Address, WrData, TX_P_Data = 0.
REQ-032 Reset mid-command SHALL abandon the command; no WrEN/RdEN/TX_D_VLD pulse after rst_n rises until a new full command arrives.

Configuration
REQ-033 Macro RF_CMD_ERR_EN: when defined, output Cmd_Err (1 bit, reset 0) SHALL pulse one cycle after an unknown opcode is received in IDLE; when undefined, the port does not exist and unknown opcodes are silently dropped.

Structure
REQ-034 Package rf_cmd_ctrl_pkg SHALL hold the state enum type and default opcode constants WR_CMD_DEF and RD_CMD_DEF.
REQ-035 The block SHALL be one module with no sub-modules; the FSM is small enough to stay flat.

Verification
REQ-036 Write: bytes AA, 05, 3C -> one-cycle WrEN with Address=5, WrData=3C; no TX_D_VLD.
REQ-037 Read: bytes BB, 02 and a model returning 0x11 with Rd_Data_VLD one cycle after RdEN -> one RdEN pulse at Address=2, then TX_D_VLD with TX_P_Data=11.
REQ-038 Back-pressure: read with TX_Busy held high 10 cycles -> TX_D_VLD stays 0 and TX_P_Data is stable, then pulses once in the cycle TX_Busy is low.
REQ-039 Unknown opcode 0x55 -> FSM stays IDLE, Busy=0; with RF_CMD_ERR_EN, Cmd_Err pulses once.
REQ-040 Reset after AA, 07 -> outputs return to 0; a following byte 3C causes no WrEN.
REQ-041 RX_D_VLD during RD_WAIT (byte AA) -> dropped; the read completes normally, then the FSM is in IDLE.
